ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single-port ram block between the CPU data port (m0) and a DMA/loader port (m1).
- Sits between the two masters and the ram slave port. It sequences complete stb phases onto the slave, so the slave always sees a stb-low cycle between phases and returns to its idle state.

Parameters:
- DAT_WIDTH, 64, data bus width in bits.
- ADR_WIDTH, 64, address bus width in bits (byte address, passed through unmodified).

Ports:
- clk_i  in  1  single system clock.
- rst_n_i  in  1  reset, asynchronous and active-low.
- m0_adr_i / m1_adr_i  in  ADR_WIDTH  master byte address.
- m0_dat_i / m1_dat_i  in  DAT_WIDTH  master write data.
- m0_we_i / m1_we_i  in  1  master write enable.
- m0_stb_i / m1_stb_i  in  1  master strobe (request).
- m0_dat_o / m1_dat_o  out  DAT_WIDTH  read data; both driven from s_dat_i.
- m0_ack_o / m1_ack_o  out  1  ack, routed only to the granted master.
- m0_err_o / m1_err_o  out  1  err, routed only to the granted master.
- s_adr_o  out  ADR_WIDTH  to ram address.
- s_dat_o  out  DAT_WIDTH  to ram write data.
- s_we_o  out  1  to ram write enable.
- s_stb_o  out  1  to ram strobe.
- s_dat_i  in  DAT_WIDTH  from ram read data.
- s_ack_i  in  1  from ram ack.
- s_err_i  in  1  from ram err.
- gnt_o  out  2  one-hot current grant ({m1,m0}); 2'b00 when idle.

Behaviour:
- State register has three states: IDLE, GNT0, GNT1. Reset (rst_n_i=0, asynchronous) forces IDLE and clears last_gnt to 0.
- Reset values:
  - s_stb_o=0, s_we_o=0.
  - All m*_ack_o and m*_err_o = 0.
  - gnt_o=00.
  - s_adr_o and s_dat_o = 0.
- IDLE:
  - s_stb_o=0 and s_we_o=0 unconditionally. This guarantees at least one stb-low cycle between phases at the slave.
  - Only m0_stb_i=1: next state GNT0.
  - Only m1_stb_i=1: next state GNT1.
  - Both=1: m0 wins (fixed priority; see Optional Feature).
  - Neither: stay in IDLE.
- GNTn:
  - s_adr_o, s_dat_o, s_we_o and s_stb_o are combinationally driven from master n.
  - mn_ack_o = s_ack_i and mn_err_o = s_err_i.
  - The other master's ack/err are held at 0. Its stb stays pending and is not dropped or acknowledged.
  - Exit: when mn_stb_i=0, next state is IDLE and last_gnt <= n.
  - The grant is held for the entire stb phase, including cycles after ack/err while stb is still high.
- Muxes select on the registered state only, so there is no combinational path from stb inputs to the grant.
- Latency:
  - Request in IDLE: 1 arbitration cycle, then s_stb_o rises. The ram acks 1 cycle after that, so the master sees ack 2 cycles after stb rises.
  - Back-to-back requests from the same or the other master cost a minimum of 1 IDLE cycle between phases.
- m0_dat_o = m1_dat_o = s_dat_i at all times. Only ack qualifies the data.
- Slave err (out-of-range address) is forwarded as-is. The arbiter never generates err itself.
- Master stb dropping before ack (abort): the grant releases on the next edge. The slave sees stb=0 in IDLE and recovers.
- Reset asserted mid-phase: s_stb_o and all acks go to 0 immediately (asynchronous). After release, arbitration restarts from IDLE with last_gnt=0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the master not equal to last_gnt wins. Alternating grants result under continuous contention (m0,m1,m0,...).
- Undefined: fixed priority, m0 always wins ties, and last_gnt is still maintained but unused.
- All other behaviour is identical in both builds.

Test Plan:
- Single read: preload ram word 2 = 64'hDEAD_BEEF_0000_0001; m1 asserts stb with adr=16, we=0 -> gnt_o=10 after 1 cycle, m1_ack_o=1 two cycles after stb, m1_dat_o=64'hDEAD_BEEF_0000_0001, m0_ack_o=0 throughout.
- Write then read: m0 writes 64'h1234 to adr=8; after the phase, m1 reads adr=8 -> m1 gets 64'h1234, and s_stb_o shows exactly one low cycle between the phases.
- Contention without macro: m0 and m1 assert stb in the same cycle, each holding stb until ack, for 4 rounds -> all 4 grants go to m0, and m1 is served only after m0 stops.
- Contention with ARB_ROUND_ROBIN_EN: same stimulus -> grant order m0,m1,m0,m1 and each master receives exactly its own ack.
- Error forwarding: m0 reads adr=64'h400 (word 128, out of range for WORDS=128) -> m0_err_o=1, m0_ack_o=0, m1_err_o=0, and the grant is released when m0 drops stb.
- Reset mid-phase: pull rst_n_i low while in GNT1 with s_stb_o=1 -> s_stb_o, m1_ack_o and gnt_o go to 0 without waiting for a clock edge; after release, a new m0 request is granted normally.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Wishbone bundle shared by the two ram masters, the ram arbiter and the ram slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ram_arbiter_if #(
    parameter int DAT_WIDTH = 64,
    parameter int ADR_WIDTH = 64
);
    logic [ADR_WIDTH-1:0] m0_adr_i;
    logic [DAT_WIDTH-1:0] m0_dat_i;
    logic                 m0_we_i;
    logic                 m0_stb_i;
    logic [DAT_WIDTH-1:0] m0_dat_o;
    logic                 m0_ack_o;
    logic                 m0_err_o;

    logic [ADR_WIDTH-1:0] m1_adr_i;
    logic [DAT_WIDTH-1:0] m1_dat_i;
    logic                 m1_we_i;
    logic                 m1_stb_i;
    logic [DAT_WIDTH-1:0] m1_dat_o;
    logic                 m1_ack_o;
    logic                 m1_err_o;

    logic [ADR_WIDTH-1:0] s_adr_o;
    logic [DAT_WIDTH-1:0] s_dat_o;
    logic                 s_we_o;
    logic                 s_stb_o;
    logic [DAT_WIDTH-1:0] s_dat_i;
    logic                 s_ack_i;
    logic                 s_err_i;

    logic [1:0]           gnt_o;

    modport slave (
        input  m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i,
        output gnt_o
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i,
        input  gnt_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master Wishbone arbiter in front of the single-port ram; one idle cycle separates stb phases.
// ARB_ROUND_ROBIN_EN: when defined, ties in IDLE go to the master that was not granted last.
module ram_arbiter #(
    parameter int DAT_WIDTH = 64,
    parameter int ADR_WIDTH = 64
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   last_gnt_r;
    logic   next_last_gnt_s;

    // Grant state and last-served master, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            last_gnt_r <= next_last_gnt_s;
        end
    end

    // Arbitration: pick a master from IDLE, hold the grant for the whole stb phase.
    always_comb begin
        next_state_s    = state_r;
        next_last_gnt_s = last_gnt_r;
        case (state_r)
            IDLE: begin
                if (bus.m0_stb_i && bus.m1_stb_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last_gnt_r) begin
                        next_state_s = GNT0;
                    end else begin
                        next_state_s = GNT1;
                    end
`else
                    next_state_s = GNT0;
`endif
                end else if (bus.m0_stb_i) begin
                    next_state_s = GNT0;
                end else if (bus.m1_stb_i) begin
                    next_state_s = GNT1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT0: begin
                if (!bus.m0_stb_i) begin
                    next_state_s    = IDLE;
                    next_last_gnt_s = 1'b0;
                end else begin
                    next_state_s = GNT0;
                end
            end
            GNT1: begin
                if (!bus.m1_stb_i) begin
                    next_state_s    = IDLE;
                    next_last_gnt_s = 1'b1;
                end else begin
                    next_state_s = GNT1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Bus muxing keyed only on the registered state, so stb never reaches gnt combinationally.
    always_comb begin
        bus.s_adr_o  = {ADR_WIDTH{1'b0}};
        bus.s_dat_o  = {DAT_WIDTH{1'b0}};
        bus.s_we_o   = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.gnt_o    = 2'b00;
        case (state_r)
            IDLE: begin
                bus.gnt_o = 2'b00;
            end
            GNT0: begin
                bus.s_adr_o  = bus.m0_adr_i;
                bus.s_dat_o  = bus.m0_dat_i;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_stb_o  = bus.m0_stb_i;
                bus.m0_ack_o = bus.s_ack_i;
                bus.m0_err_o = bus.s_err_i;
                bus.gnt_o    = 2'b01;
            end
            GNT1: begin
                bus.s_adr_o  = bus.m1_adr_i;
                bus.s_dat_o  = bus.m1_dat_i;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_stb_o  = bus.m1_stb_i;
                bus.m1_ack_o = bus.s_ack_i;
                bus.m1_err_o = bus.s_err_i;
                bus.gnt_o    = 2'b10;
            end
            default: begin
                bus.gnt_o = 2'b00;
            end
        endcase
    end

    // Read data is broadcast; only ack qualifies it.
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a 128-word ram slave, directed master traffic, and a per-cycle
// reference model of phase ownership plus a data scoreboard.
module tb_ram_arbiter;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    ram_arbiter_if #(.DAT_WIDTH(64), .ADR_WIDTH(64)) bus ();

    ram_arbiter #(.DAT_WIDTH(64), .ADR_WIDTH(64)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ram slave: acks (or errs beyond word 127) once per stb phase, one cycle after stb.
    logic [63:0] ram_mem [0:127];
    logic        ram_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s_ack_i <= 1'b0;
            bus.s_err_i <= 1'b0;
            bus.s_dat_i <= 64'd0;
            ram_done    <= 1'b0;
            ram_mem[2]  <= 64'hDEAD_BEEF_0000_0001;
        end else begin
            bus.s_ack_i <= 1'b0;
            bus.s_err_i <= 1'b0;
            if (!bus.s_stb_o) begin
                ram_done <= 1'b0;
            end else if (!ram_done) begin
                ram_done <= 1'b1;
                if (bus.s_adr_o[63:10] != 54'd0) begin
                    bus.s_err_i <= 1'b1;
                end else begin
                    bus.s_ack_i <= 1'b1;
                    if (bus.s_we_o) ram_mem[bus.s_adr_o[9:3]] <= bus.s_dat_o;
                    else            bus.s_dat_i <= ram_mem[bus.s_adr_o[9:3]];
                end
            end
        end
    end

    // Reference model: who owns the slave (0 none, 1 m0, 2 m1) and who was served last.
    int owner;
    int last_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= 0;
            last_m <= 0;
        end else if (owner == 1) begin
            if (!bus.m0_stb_i) begin owner <= 0; last_m <= 0; end
        end else if (owner == 2) begin
            if (!bus.m1_stb_i) begin owner <= 0; last_m <= 1; end
        end else if (bus.m0_stb_i && bus.m1_stb_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner <= (last_m == 0) ? 2 : 1;
`else
            owner <= 1;
`endif
        end else if (bus.m0_stb_i) begin
            owner <= 1;
        end else if (bus.m1_stb_i) begin
            owner <= 2;
        end
    end

    // Expected memory contents, updated from acknowledged writes.
    logic [63:0] ref_mem [0:127];
    logic [1:0]  prev_gnt;
    int          gnt_log[$];

    // Per-cycle comparison of every DUT output against the model, on the falling edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_mem[2] <= 64'hDEAD_BEEF_0000_0001;
            prev_gnt   <= 2'b00;
        end
        if (!clk) begin
            logic [1:0]  e_gnt;
            logic [63:0] e_adr, e_dat;
            logic [1:0]  e_ctl;
            logic [3:0]  e_resp;
            e_gnt  = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            e_adr  = (owner == 1) ? bus.m0_adr_i : (owner == 2) ? bus.m1_adr_i : 64'd0;
            e_dat  = (owner == 1) ? bus.m0_dat_i : (owner == 2) ? bus.m1_dat_i : 64'd0;
            e_ctl  = (owner == 1) ? {bus.m0_we_i, bus.m0_stb_i} :
                     (owner == 2) ? {bus.m1_we_i, bus.m1_stb_i} : 2'b00;
            e_resp = {(owner == 2) & bus.s_err_i, (owner == 2) & bus.s_ack_i,
                      (owner == 1) & bus.s_err_i, (owner == 1) & bus.s_ack_i};
            chk("gnt", {62'd0, bus.gnt_o}, {62'd0, e_gnt});
            chk("s_adr", bus.s_adr_o, e_adr);
            chk("s_dat", bus.s_dat_o, e_dat);
            chk("s_we_stb", {62'd0, bus.s_we_o, bus.s_stb_o}, {62'd0, e_ctl});
            chk("ack_err", {60'd0, bus.m1_err_o, bus.m1_ack_o, bus.m0_err_o, bus.m0_ack_o},
                {60'd0, e_resp});
            chk("m_dat", {bus.m0_dat_o ^ bus.s_dat_i} | {bus.m1_dat_o ^ bus.s_dat_i}, 64'd0);
            if (rst_n && bus.m0_ack_o) begin
                if (bus.m0_we_i) ref_mem[bus.m0_adr_i[9:3]] <= bus.m0_dat_i;
                else chk("m0_rdata", bus.m0_dat_o, ref_mem[bus.m0_adr_i[9:3]]);
            end
            if (rst_n && bus.m1_ack_o) begin
                if (bus.m1_we_i) ref_mem[bus.m1_adr_i[9:3]] <= bus.m1_dat_i;
                else chk("m1_rdata", bus.m1_dat_o, ref_mem[bus.m1_adr_i[9:3]]);
            end
            if (bus.gnt_o != prev_gnt && bus.gnt_o != 2'b00) gnt_log.push_back(bus.gnt_o == 2'b10 ? 1 : 0);
            prev_gnt <= bus.gnt_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic [63:0] adr, input logic [63:0] dat, input logic we);
        if (m == 0) begin
            bus.m0_adr_i = adr; bus.m0_dat_i = dat; bus.m0_we_i = we; bus.m0_stb_i = 1'b1;
        end else begin
            bus.m1_adr_i = adr; bus.m1_dat_i = dat; bus.m1_we_i = we; bus.m1_stb_i = 1'b1;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) bus.m0_stb_i = 1'b0;
        else        bus.m1_stb_i = 1'b0;
    endtask

    // Wait (bounded) for ack or err to the given master.
    task automatic wait_term(input int m);
        bit got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            tick();
            got = (m == 0) ? (bus.m0_ack_o | bus.m0_err_o) : (bus.m1_ack_o | bus.m1_err_o);
        end
        if (!got) chk("term_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_master(input int m, input int rounds);
        for (int r = 0; r < rounds; r++) begin
            req(m, (m == 0) ? 64'd16 : 64'd8, 64'd0, 1'b0);
            wait_term(m);
            drop(m);
            tick();
        end
    endtask

    initial begin
        int gap;
        int base;
        int exp_order [8];
        rst_n = 1'b0;
        bus.m0_adr_i = 64'd0; bus.m0_dat_i = 64'd0; bus.m0_we_i = 1'b0; bus.m0_stb_i = 1'b0;
        bus.m1_adr_i = 64'd0; bus.m1_dat_i = 64'd0; bus.m1_we_i = 1'b0; bus.m1_stb_i = 1'b0;
        tick(); tick();
        chk("rst_gnt", {62'd0, bus.gnt_o}, 64'd0);
        chk("rst_stb_we", {62'd0, bus.s_stb_o, bus.s_we_o}, 64'd0);
        chk("rst_acks", {60'd0, bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}, 64'd0);
        chk("rst_adr", bus.s_adr_o, 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Single read by m1 of word 2.
        req(1, 64'd16, 64'd0, 1'b0);
        tick();
        chk("rd_gnt_1cyc", {62'd0, bus.gnt_o}, 64'd2);
        chk("rd_ack_early", {63'd0, bus.m1_ack_o}, 64'd0);
        tick();
        chk("rd_ack_2cyc", {63'd0, bus.m1_ack_o}, 64'd1);
        chk("rd_data", bus.m1_dat_o, 64'hDEAD_BEEF_0000_0001);
        chk("rd_m0_ack", {63'd0, bus.m0_ack_o}, 64'd0);
        drop(1);
        tick(); tick();

        // m0 writes word 1 (adr 8), then m1 reads it back with one idle cycle between phases.
        req(0, 64'd8, 64'h1234, 1'b1);
        wait_term(0);
        chk("wr_ack", {63'd0, bus.m0_ack_o}, 64'd1);
        drop(0);
        req(1, 64'd8, 64'd0, 1'b0);
        gap = 0;
        for (int c = 0; c < 16 && bus.gnt_o != 2'b10; c++) begin
            tick();
            if (bus.gnt_o == 2'b00) begin
                gap++;
                chk("gap_stb_low", {63'd0, bus.s_stb_o}, 64'd0);
            end
        end
        chk("idle_gap", gap, 64'd1);
        wait_term(1);
        chk("wr_rd_data", bus.m1_dat_o, 64'h1234);
        drop(1);
        tick(); tick();

        // Contention: both masters request together for four rounds each.
        base = gnt_log.size();
        fork
            run_master(0, 4);
            run_master(1, 4);
        join
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        chk("cont_phases", gnt_log.size() - base, 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < gnt_log.size()) chk($sformatf("cont_order%0d", i), gnt_log[base + i], exp_order[i]);
        end
        tick();

        // Out-of-range read by m0: error forwarded, grant released when stb drops.
        req(0, 64'h400, 64'd0, 1'b0);
        wait_term(0);
        chk("err_resp", {60'd0, bus.m0_err_o, bus.m0_ack_o, bus.m1_err_o, bus.m1_ack_o}, 64'h8);
        drop(0);
        tick();
        chk("err_release", {62'd0, bus.gnt_o}, 64'd0);
        tick();

        // Reset asserted mid-phase, between clock edges.
        req(1, 64'd16, 64'd0, 1'b0);
        wait_term(1);
        chk("pre_rst_stb", {62'd0, bus.gnt_o, bus.s_stb_o}, 64'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {60'd0, bus.gnt_o, bus.s_stb_o, bus.m1_ack_o}, 64'd0);
        drop(1);
        tick();
        #2 rst_n = 1'b1;
        tick();
        req(0, 64'd8, 64'd0, 1'b0);
        tick();
        chk("post_rst_gnt", {62'd0, bus.gnt_o}, 64'd1);
        tick();
        chk("post_rst_ack", {63'd0, bus.m0_ack_o}, 64'd1);
        chk("post_rst_data", bus.m0_dat_o, 64'h1234);
        drop(0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
